// File: rtl/pla_risc_opcode_issuer.sv
// Opcode-issue sequencer: buffers encoded requests, replays each head entry for
// rpt+1 beats on x0..x7. Optional illegal-request counter under RISC_ISSUE_ILLCNT_EN.
module pla_risc_opcode_issuer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_grp,
    input  logic [4:0] in_fn,
    input  logic [1:0] in_rpt,
    input  logic       flush,
    output logic       op_valid,
    input  logic       op_ready,
    output logic       x0,
    output logic       x1,
    output logic       x2,
    output logic       x3,
    output logic       x4,
    output logic       x5,
    output logic       x6,
    output logic       x7,
    output logic       err,
    output logic [7:0] ill_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [1:0]    beat_cnt;
    logic [9:0]    head;
    logic          accept;
    logic          illegal;
    logic          push;
    logic          beat;
    logic          pop;

    assign head     = mem[rd_ptr];
    assign in_ready = (count != CW'(DEPTH));
    assign op_valid = (count != '0);
    assign accept   = in_valid & in_ready;
    assign illegal  = (in_grp == 3'b111) & in_fn[4];
    assign push     = accept & ~illegal;
    assign beat     = op_valid & op_ready;
    assign pop      = beat & (beat_cnt == head[1:0]);

    // Gated so the pins read zero whenever no entry is presented, including in reset.
    assign {x0, x1, x2, x3, x4, x5, x6, x7} = op_valid ? head[9:2] : 8'h00;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_grp, in_fn, in_rpt};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= 2'd0;
            err      <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= 2'd0;
            err      <= 1'b0;
        end else begin
            err <= accept & illegal;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + AW'(1);
                beat_cnt <= 2'd0;
            end else if (beat) begin
                beat_cnt <= beat_cnt + 2'd1;
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

`ifdef RISC_ISSUE_ILLCNT_EN
    // Requests dropped in a flush cycle are discarded silently, so they are not counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt <= 8'h00;
        end else if (accept && illegal && !flush && ill_cnt != 8'hFF) begin
            ill_cnt <= ill_cnt + 8'h01;
        end
    end
`else
    assign ill_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_pla_risc_opcode_issuer.sv
// Bench for pla_risc_opcode_issuer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pla_risc_opcode_issuer;
    localparam int DEPTH = 4;
`ifdef RISC_ISSUE_ILLCNT_EN
    localparam int ILL1   = 1;
    localparam int ILLMAX = 255;
`else
    localparam int ILL1   = 0;
    localparam int ILLMAX = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_grp = '0;
    logic [4:0] in_fn = '0;
    logic [1:0] in_rpt = '0;
    logic       flush = 1'b0;
    logic       op_valid;
    logic       op_ready = 1'b0;
    logic       x0, x1, x2, x3, x4, x5, x6, x7;
    logic       err;
    logic [7:0] ill_cnt;
    logic [7:0] xb;

    assign xb = {x0, x1, x2, x3, x4, x5, x6, x7};

    pla_risc_opcode_issuer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_grp(in_grp), .in_fn(in_fn), .in_rpt(in_rpt), .flush(flush),
        .op_valid(op_valid), .op_ready(op_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .err(err), .ill_cnt(ill_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of pending requests plus the beats done on the head.
    typedef struct {
        logic [2:0] g;
        logic [4:0] f;
        logic [1:0] r;
    } req_t;

    req_t     q[$];
    int       mbeat;
    bit       merr;
    int       mill;
    logic [7:0] beat_log[$];

    always @(posedge clk or negedge rst_n) begin
        bit acc, bt;
        req_t e;
        if (!rst_n) begin
            q.delete();
            mbeat = 0;
            merr  = 0;
            mill  = 0;
        end else begin
            acc  = in_valid && (q.size() < DEPTH);
            bt   = (q.size() != 0) && op_ready;
            merr = 0;
            if (flush) begin
                q.delete();
                mbeat = 0;
            end else begin
                if (bt) begin
                    if (mbeat == int'(q[0].r)) begin
                        void'(q.pop_front());
                        mbeat = 0;
                    end else begin
                        mbeat++;
                    end
                end
                if (acc) begin
                    if (in_grp == 3'd7 && in_fn[4]) begin
                        merr = 1;
`ifdef RISC_ISSUE_ILLCNT_EN
                        if (mill < 255) mill++;
`endif
                    end else begin
                        e.g = in_grp; e.f = in_fn; e.r = in_rpt;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("op_valid", 32'(op_valid), 32'(q.size() != 0));
            check("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            check("err", 32'(err), 32'(merr));
            check("ill_cnt", 32'(ill_cnt), 32'(mill));
            if (q.size() != 0) begin
                check("opcode", 32'(xb), 32'({q[0].g, q[0].f}));
            end
            if (op_valid && op_ready) beat_log.push_back(xb);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [2:0] g, input logic [4:0] f, input logic [1:0] r);
        in_valid = 1'b1; in_grp = g; in_fn = f; in_rpt = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #12;
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_x", 32'(xb), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ill_cnt", 32'(ill_cnt), 32'd0);
        #11 rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Single beat
        op_ready = 1'b1;
        req(3'b010, 5'b00000, 2'd0);
        tick();
        in_valid = 1'b0;
        check("single_valid", 32'(op_valid), 32'd1);
        check("single_x", 32'(xb), 32'h40);
        tick();
        check("single_done", 32'(op_valid), 32'd0);

        // Repeat plus stall
        op_ready = 1'b0;
        beat_log.delete();
        req(3'b001, 5'b11000, 2'd2);
        tick();
        in_valid = 1'b0;
        tick();
        check("stall_x0", 32'(xb), 32'h38);
        tick();
        check("stall_x1", 32'(xb), 32'h38);
        op_ready = 1'b1;
        repeat (3) tick();
        check("rpt_popped", 32'(op_valid), 32'd0);
        tick();
        check("rpt_beats", 32'(beat_log.size()), 32'd3);
        if (beat_log.size() == 3) check("rpt_beat_op", 32'(beat_log[2]), 32'h38);

        // Full / backpressure
        op_ready = 1'b0;
        beat_log.delete();
        for (int i = 0; i < 4; i++) begin
            req(3'(i), 5'(i + 1), 2'd0);
            tick();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        req(3'd4, 5'd5, 2'd0);
        tick();
        tick();
        op_ready = 1'b1;
        tick();
        check("fifth_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        check("full_count", 32'(beat_log.size()), 32'd5);
        if (beat_log.size() == 5) begin
            check("order0", 32'(beat_log[0]), 32'h01);
            check("order1", 32'(beat_log[1]), 32'h22);
            check("order2", 32'(beat_log[2]), 32'h43);
            check("order3", 32'(beat_log[3]), 32'h64);
            check("order4", 32'(beat_log[4]), 32'h85);
        end

        // Illegal request
        req(3'b111, 5'b10000, 2'd0);
        tick();
        in_valid = 1'b0;
        check("ill_err", 32'(err), 32'd1);
        check("ill_no_valid", 32'(op_valid), 32'd0);
        check("ill_cnt1", 32'(ill_cnt), 32'(ILL1));
        tick();
        check("ill_err_clr", 32'(err), 32'd0);
        req(3'b111, 5'b11111, 2'd3);
        repeat (256) tick();
        in_valid = 1'b0;
        tick();
        check("ill_sat", 32'(ill_cnt), 32'(ILLMAX));

        // Flush collision with an illegal request in the same cycle
        op_ready = 1'b0;
        req(3'b000, 5'b00011, 2'd3);
        tick();
        req(3'b011, 5'b01010, 2'd0);
        tick();
        req(3'b101, 5'b00110, 2'd1);
        tick();
        in_valid = 1'b0;
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
        check("mid_rpt_x", 32'(xb), 32'h03);
        flush = 1'b1;
        req(3'b111, 5'b10001, 2'd0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_valid", 32'(op_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_err", 32'(err), 32'd0);
        check("flush_ill", 32'(ill_cnt), 32'(ILLMAX));
        tick();
        check("flush_empty", 32'(op_valid), 32'd0);

        // Asynchronous reset mid-stream
        req(3'b110, 5'b01111, 2'd3);
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", 32'(op_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", 32'(op_valid), 32'd0);
        check("async_x", 32'(xb), 32'd0);
        check("async_ill", 32'(ill_cnt), 32'd0);
        tick();
        #2 rst_n = 1'b1;
        tick();
        check("post_rst_valid", 32'(op_valid), 32'd0);
        check("post_rst_ready", 32'(in_ready), 32'd1);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
